fetch_queue: RTL

- Instruction-fetch stage fed by the PC unit's redirect outputs (`pcsrc`/jump target).
- Holds its own fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PC and PC+4 in a small FIFO.
- Presents them to decode through a second valid/ready handshake.
- On redirect, squashes all buffered and in-flight fetches.

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage issuing credit-limited in-order imem requests and buffering results in a FIFO.
// Define FETCH_MISALIGN_EN to add the sticky misaligned-redirect fault (misalign_fault / misalign_pc).
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'hBFC00000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_EN
    output logic             misalign_fault,
    output logic [WIDTH-1:0] misalign_pc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [WIDTH-1:0] r_instr_q [DEPTH];
    logic [WIDTH-1:0] r_pc_q    [DEPTH];

    logic [CW:0]      w_used;
    logic [CW-1:0]    w_inflight;
    logic [WIDTH-1:0] w_target;
    logic             w_issue_ok;
    logic             w_flush;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;

    assign w_flush     = rst || redirect;
    assign w_used      = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid = !w_flush && w_issue_ok && (w_used < LP_DEPTH);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_rsp_drop  = imem_rsp_valid && (r_drop != '0);
    assign w_push      = imem_rsp_valid && (r_drop == '0) && !w_flush;
    assign w_pop       = (r_count != '0) && out_ready && !w_flush;
    // Requests still owed a response once this cycle's response (if any) has been consumed.
    assign w_inflight  = r_outstanding - CW'(imem_rsp_valid);

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

`ifdef FETCH_MISALIGN_EN
    logic             r_fault;
    logic [WIDTH-1:0] r_misalign_pc;

    assign w_target   = redirect_pc;
    assign w_issue_ok = !r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault       <= 1'b0;
            r_misalign_pc <= '0;
        end else if (redirect) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
            if (redirect_pc[1:0] != 2'b00) r_misalign_pc <= redirect_pc;
        end
    end

    assign misalign_fault = r_fault;
    assign misalign_pc    = r_misalign_pc;
`else
    assign w_target   = redirect_pc & ~WIDTH'(3);
    assign w_issue_ok = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_outstanding <= w_inflight;
            r_drop        <= w_inflight;
        end else if (redirect) begin
            // Everything still in flight belongs to the old path and is discarded on return.
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_outstanding <= w_inflight;
            r_drop        <= w_inflight;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + WIDTH'(4);
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + WIDTH'(4);
                r_wptr   <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_rsp_drop) r_drop <= r_drop - CW'(1);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            r_outstanding <= w_inflight + CW'(w_req_fire);
        end
    end

    // NOTE: the storage array has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wptr] <= imem_rsp_data;
            r_pc_q[r_wptr]    <= r_rsp_pc;
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_instr    = r_instr_q[r_rptr];
    assign out_pc       = r_pc_q[r_rptr];
    assign out_pc_plus4 = out_pc + WIDTH'(4);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (r_outstanding == '0)));

endmodule
